// File: rtl/if_pc_fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
// Holds the pc_wr_sel encoding reused from the single-register PC,
// the fetch increment and the tag layout kept per outstanding request.
package if_pc_fetch_pkg;

    // Redirect target select; encodings other than PC_WR_JALR behave as PC_WR_ALU
    typedef enum logic [1:0] {
        PC_WR_ALU  = 2'b00,
        PC_WR_JALR = 2'b01
    } pc_wr_sel_e;

    // Byte distance between consecutive fetch addresses
    localparam int unsigned PC_FETCH_INC = 32'd4;

    // Reference width of the tag layout below
    localparam int unsigned PC_TAG_XLEN = 32'd32;

    // One tag entry: requesting PC plus a live flag cleared by a redirect
    typedef struct packed {
        logic [PC_TAG_XLEN-1:0] pc;
        logic                   live;
    } pc_tag_t;

endpackage

// File: rtl/if_pc_fetch_if.sv
// Instruction memory request/response bus.
// master: fetch unit (drives requests); slave: instruction memory.
interface if_pc_fetch_if #(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/if_pc_tag_fifo.sv
// PC tag FIFO: one entry per outstanding fetch request, in issue order.
// Each entry keeps the requesting PC and a live bit; kill_all_i clears every
// live bit at once while the entries themselves remain until popped.
module if_pc_tag_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [XLEN-1:0]            push_pc_i,
    input  logic                       pop_i,
    input  logic                       kill_all_i,
    output logic [XLEN-1:0]            head_pc_o,
    output logic                       head_live_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem_r [DEPTH];
    logic [DEPTH-1:0] live_r;
    logic [DEPTH-1:0] live_s;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign push_ok_s   = push_i & ~full_s;
    assign pop_ok_s    = pop_i & ~empty_s;
    assign head_pc_o   = pc_mem_r[rd_ptr_r];
    assign head_live_o = live_r[rd_ptr_r];
    assign count_o     = count_r;

    // Next live mask: a kill wipes every entry, a push marks its new slot live
    always_comb begin
        live_s = live_r;
        if (kill_all_i) begin
            live_s = {DEPTH{1'b0}};
        end else begin
            live_s = live_r;
        end
        if (push_ok_s) begin
            live_s[wr_ptr_r] = 1'b1;
        end else begin
            live_s = live_s;
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CW'(1'b1);
            2'b01:   count_s = count_r - CW'(1'b1);
            default: count_s = count_r;
        endcase
    end

    // Pointer, occupancy, live-bit and tag storage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            live_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            count_r <= count_s;
            live_r  <= live_s;
            if (push_ok_s) begin
                pc_mem_r[wr_ptr_r] <= push_pc_i;
                wr_ptr_r           <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end

endmodule

// File: rtl/if_pc_fetch.sv
// Instruction fetch PC generator with outstanding-request tracking.
// Issues word-aligned fetch addresses over a valid/ready bus, remembers the
// PC of every accepted request and pairs it with the in-order response.
// A redirect kills all in-flight requests in one cycle.
// Optional build macro IF_PC_MISALIGN_CHK_EN: keep redirect bit 1, flag a
// misaligned target on misalign_o and halt issue until the next redirect.
module if_pc_fetch
    import if_pc_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_en_i,
    input  logic                 redirect_i,
    input  logic [1:0]           redirect_sel_i,
    input  logic [XLEN-1:0]      redirect_addr_i,
    if_pc_fetch_if.master        bus,
    output logic                 inst_valid_o,
    output logic [XLEN-1:0]      inst_data_o,
    output logic [XLEN-1:0]      inst_pc_o,
    output logic [XLEN-1:0]      pc_prev_o,
    output logic                 err_o,
    output logic                 misalign_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] jalr_tgt_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] head_pc_s;
    logic            head_live_s;
    logic [CW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;
    logic            req_valid_s;
    logic            issue_s;
    logic            pop_s;
    logic            deliver_s;
    logic            err_set_s;

    assign full_s    = (count_s == CW'(DEPTH));
    assign empty_s   = (count_s == {CW{1'b0}});

`ifdef IF_PC_MISALIGN_CHK_EN
    logic halted_r;
    assign req_valid_s = fetch_en_i & ~full_s & ~redirect_i & ~halted_r;
`else
    assign req_valid_s = fetch_en_i & ~full_s & ~redirect_i;
`endif

    assign issue_s       = req_valid_s & bus.req_ready;
    assign pop_s         = bus.rsp_valid & ~empty_s;
    assign deliver_s     = pop_s & head_live_s & ~redirect_i;
    assign err_set_s     = bus.rsp_valid & empty_s;
    assign bus.req_valid = req_valid_s;
    assign bus.req_addr  = fetch_pc_r;

    // Redirect target: JALR clears bit 0, every other select passes the ALU result
    always_comb begin
        jalr_tgt_s = redirect_addr_i;
        if (redirect_sel_i == PC_WR_JALR) begin
            jalr_tgt_s[0] = 1'b0;
        end else begin
            jalr_tgt_s = redirect_addr_i;
        end
    end

`ifdef IF_PC_MISALIGN_CHK_EN
    assign target_s = jalr_tgt_s;
`else
    logic unused_tgt_bits_s;
    assign target_s          = {jalr_tgt_s[XLEN-1:2], 2'b00};
    assign unused_tgt_bits_s = ^jalr_tgt_s[1:0];
`endif

    if_pc_tag_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (issue_s),
        .push_pc_i   (fetch_pc_r),
        .pop_i       (pop_s),
        .kill_all_i  (redirect_i),
        .head_pc_o   (head_pc_s),
        .head_live_o (head_live_s),
        .count_o     (count_s)
    );

    // Fetch PC: redirect loads the target, an accepted request advances by one word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_VEC;
        end else if (redirect_i) begin
            fetch_pc_r <= target_s;
        end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(PC_FETCH_INC);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Delivery registers toward ID and the sticky empty-response error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inst_valid_o <= 1'b0;
            inst_data_o  <= {XLEN{1'b0}};
            inst_pc_o    <= {XLEN{1'b0}};
            pc_prev_o    <= {XLEN{1'b0}};
            err_o        <= 1'b0;
        end else begin
            inst_valid_o <= deliver_s;
            err_o        <= err_o | err_set_s;
            if (deliver_s) begin
                inst_data_o <= bus.rsp_data;
                inst_pc_o   <= head_pc_s;
                pc_prev_o   <= inst_pc_o;
            end
        end
    end

`ifdef IF_PC_MISALIGN_CHK_EN
    // Halt state and one-cycle misalign pulse, both decided on each redirect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted_r   <= 1'b0;
            misalign_o <= 1'b0;
        end else if (redirect_i) begin
            halted_r   <= target_s[1];
            misalign_o <= target_s[1];
        end else begin
            halted_r   <= halted_r;
            misalign_o <= 1'b0;
        end
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule
